ysyx_22041071_wb: RTL and testbench
===================================

Name: ysyx_22041071_wb

Overview:
- Write-back stage directly downstream of the memory-access stage.
- Accepts one retiring instruction per cycle over a valid/ready handshake and writes its result into the 32x64 integer register file, which this block owns.
- Serves two combinational read ports to decode with same-cycle write bypass.
- Counts retired instructions, detects ebreak to halt the core, and drives a registered one-cycle commit record for the difftest harness.

Parameters:
- XLEN, 64, data and address width.
- HALT_INS, 32'h0010_0073, instruction encoding that halts the core (ebreak).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_pc  in  XLEN  PC of retiring instruction
- in_ins  in  32  instruction word
- in_reg_w_en  in  1  register write enable
- in_rdest  in  5  destination register index
- in_wb_data  in  XLEN  write-back value (ALU result or load data)
- rs1_idx  in  5  read port 1 index
- rs1_data  out  XLEN  read port 1 data
- rs2_idx  in  5  read port 2 index
- rs2_data  out  XLEN  read port 2 data
- retire_cnt  out  64  retired-instruction counter
- halt  out  1  core halted (sticky)
- halt_code  out  XLEN  value of x10 at the halting instruction
- cmt_valid  out  1  one-cycle commit pulse
- cmt_pc  out  XLEN  committed PC
- cmt_ins  out  32  committed instruction
- cmt_wen  out  1  committed register write enable
- cmt_rdest  out  5  committed destination index
- cmt_wdata  out  XLEN  committed write data

Behaviour:
- Clock and reset: single clock clk. Synchronous, active-high reset.
- Reset values: every output register is 0, all 32 registers are 0, and the FSM enters RUN.
- Handshake: hs = in_valid & in_ready. in_ready = 1 in RUN and 0 in HALT. Nothing is accepted while in_ready = 0.
- Register write: on a hs edge with in_reg_w_en = 1 and in_rdest != 0, rf[in_rdest] <= in_wb_data.
  - x0 is never written and always reads 0.
  - A write to x0 still commits, with cmt_wen = in_reg_w_en as presented.
- Read ports: purely combinational. rsN_data is 0 when rsN_idx = 0.
- Bypass: if hs & in_reg_w_en & in_rdest == rsN_idx != 0, rsN_data = in_wb_data in that same cycle. Otherwise rsN_data = rf[rsN_idx].
- Commit record: on hs, the cmt_* registers latch the in_* values and cmt_valid <= 1 for exactly the next cycle. Without hs, cmt_valid <= 0 and the other cmt_* fields hold.
  - Latency from hs edge to cmt_valid high: 1 cycle.
- retire_cnt: increments by 1 on every hs edge, including the halting instruction. It wraps modulo 2^64 with no saturation.
- FSM:
  - RUN: on hs with in_ins == HALT_INS, go to HALT. That edge also sets halt <= 1 and halt_code <= rf[10]; ebreak writes no register, so no bypass applies.
  - HALT: absorbing until reset. halt stays 1, in_ready = 0, and cmt_valid drops after the ebreak commit pulse.
- Simultaneous events: a register write and a read of the same index in one cycle use the bypass value. Reset overrides hs in the same cycle, so no write, count or commit occurs.
- Reset mid-operation: pending upstream data is ignored. The register file, counter, halt state and commit record all clear at the next edge.

Optional Feature:
- Macro: YSYX_22041071_DIFFTEST_EN.
- Defined: the cmt_* outputs behave as described above.
- Undefined: the cmt_* registers are not built and all cmt_* outputs are tied to 0. Register file, halt and retire_cnt behaviour are unchanged.

Test Plan:
- Write then read: hs with rdest=5, wdata=64'hDEAD_BEEF_0000_0001, rs1_idx=5 in the same cycle -> rs1_data = 64'hDEAD_BEEF_0000_0001 via bypass; next cycle, without hs -> rs1_data still equals it from rf; cmt_valid = 1 for one cycle with cmt_rdest = 5.
- x0 protection: hs with rdest=0, wdata=64'hFFFF_FFFF_FFFF_FFFF, rs2_idx=0 -> rs2_data = 0 in that cycle and after; retire_cnt increments by 1.
- Backpressure-free streaming: 10 back-to-back hs with in_valid held at 1 -> retire_cnt = 10; cmt_valid high for 10 consecutive cycles, each lagging its hs by 1.
- Halt: write x10 = 0, then hs with in_ins = 32'h0010_0073 -> next cycle halt = 1, halt_code = 0, in_ready = 0; a later in_valid = 1 leaves retire_cnt unchanged.
- Reset override: assert reset in the same cycle as hs with rdest=3 after a prior write x3 = 7 -> next cycle rs1_idx=3 gives rs1_data = 0, retire_cnt = 0, halt = 0, cmt_valid = 0.
- Macro off: build without YSYX_22041071_DIFFTEST_EN and repeat the write/read scenario -> rs1_data matches the macro-on result; all cmt_* outputs remain 0.

Source files
------------

// File: rtl/ysyx_22041071_wb.sv
// Write-back stage: owns the 32x64 register file, retires one instruction per cycle and halts on ebreak.
// Define YSYX_22041071_DIFFTEST_EN to build the registered cmt_* commit record; otherwise cmt_* are tied to 0.
module ysyx_22041071_wb #(
    parameter int unsigned XLEN     = 64,
    parameter logic [31:0] HALT_INS = 32'h0010_0073
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_ins,
    input  logic            in_reg_w_en,
    input  logic [4:0]      in_rdest,
    input  logic [XLEN-1:0] in_wb_data,
    input  logic [4:0]      rs1_idx,
    output logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      rs2_idx,
    output logic [XLEN-1:0] rs2_data,
    output logic [63:0]     retire_cnt,
    output logic            halt,
    output logic [XLEN-1:0] halt_code,
    output logic            cmt_valid,
    output logic [XLEN-1:0] cmt_pc,
    output logic [31:0]     cmt_ins,
    output logic            cmt_wen,
    output logic [4:0]      cmt_rdest,
    output logic [XLEN-1:0] cmt_wdata
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] rf_q [32];
    logic [XLEN-1:0] rf_d [32];
    logic [63:0]     retire_cnt_q, retire_cnt_d;
    logic            halt_q, halt_d;
    logic [XLEN-1:0] halt_code_q, halt_code_d;

    logic hs;
    logic rf_we;
    logic is_halt_ins;

    assign in_ready    = (state_q == ST_RUN);
    assign hs          = in_valid & in_ready;
    assign rf_we       = hs & in_reg_w_en & (in_rdest != 5'd0);
    assign is_halt_ins = (in_ins == HALT_INS);

    // Reads see the value being written this cycle so decode never stalls on write-back.
    always_comb begin
        rs1_data = '0;
        if (rs1_idx != 5'd0) begin
            if (rf_we && (in_rdest == rs1_idx)) rs1_data = in_wb_data;
            else                                rs1_data = rf_q[rs1_idx];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_idx != 5'd0) begin
            if (rf_we && (in_rdest == rs2_idx)) rs2_data = in_wb_data;
            else                                rs2_data = rf_q[rs2_idx];
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (rf_we) rf_d[in_rdest] = in_wb_data;
    end

    always_comb begin
        state_d      = state_q;
        retire_cnt_d = retire_cnt_q;
        halt_d       = halt_q;
        halt_code_d  = halt_code_q;
        if (hs) retire_cnt_d = retire_cnt_q + 64'd1;
        case (state_q)
            ST_RUN: begin
                if (hs && is_halt_ins) begin
                    state_d     = ST_HALT;
                    halt_d      = 1'b1;
                    halt_code_d = rf_q[10];
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            retire_cnt_q <= '0;
            halt_q       <= 1'b0;
            halt_code_q  <= '0;
            for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            retire_cnt_q <= retire_cnt_d;
            halt_q       <= halt_d;
            halt_code_q  <= halt_code_d;
            rf_q         <= rf_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign halt       = halt_q;
    assign halt_code  = halt_code_q;

`ifdef YSYX_22041071_DIFFTEST_EN
    logic            cmt_valid_q, cmt_valid_d;
    logic [XLEN-1:0] cmt_pc_q, cmt_pc_d;
    logic [31:0]     cmt_ins_q, cmt_ins_d;
    logic            cmt_wen_q, cmt_wen_d;
    logic [4:0]      cmt_rdest_q, cmt_rdest_d;
    logic [XLEN-1:0] cmt_wdata_q, cmt_wdata_d;

    always_comb begin
        cmt_valid_d = hs;
        cmt_pc_d    = cmt_pc_q;
        cmt_ins_d   = cmt_ins_q;
        cmt_wen_d   = cmt_wen_q;
        cmt_rdest_d = cmt_rdest_q;
        cmt_wdata_d = cmt_wdata_q;
        if (hs) begin
            cmt_pc_d    = in_pc;
            cmt_ins_d   = in_ins;
            cmt_wen_d   = in_reg_w_en;
            cmt_rdest_d = in_rdest;
            cmt_wdata_d = in_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmt_valid_q <= 1'b0;
            cmt_pc_q    <= '0;
            cmt_ins_q   <= '0;
            cmt_wen_q   <= 1'b0;
            cmt_rdest_q <= '0;
            cmt_wdata_q <= '0;
        end else begin
            cmt_valid_q <= cmt_valid_d;
            cmt_pc_q    <= cmt_pc_d;
            cmt_ins_q   <= cmt_ins_d;
            cmt_wen_q   <= cmt_wen_d;
            cmt_rdest_q <= cmt_rdest_d;
            cmt_wdata_q <= cmt_wdata_d;
        end
    end

    assign cmt_valid = cmt_valid_q;
    assign cmt_pc    = cmt_pc_q;
    assign cmt_ins   = cmt_ins_q;
    assign cmt_wen   = cmt_wen_q;
    assign cmt_rdest = cmt_rdest_q;
    assign cmt_wdata = cmt_wdata_q;
`else
    // The PC only feeds the commit record, so it is otherwise intentionally dropped.
    logic unused_pc;
    assign unused_pc = ^in_pc;

    assign cmt_valid = 1'b0;
    assign cmt_pc    = '0;
    assign cmt_ins   = '0;
    assign cmt_wen   = 1'b0;
    assign cmt_rdest = '0;
    assign cmt_wdata = '0;
`endif

endmodule

// File: tb/tb_ysyx_22041071_wb.sv
// Directed bench for ysyx_22041071_wb; commit-record expectations follow YSYX_22041071_DIFFTEST_EN.
module tb_ysyx_22041071_wb;

`ifdef YSYX_22041071_DIFFTEST_EN
    localparam bit DT = 1'b1;
`else
    localparam bit DT = 1'b0;
`endif
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_ins;
    logic        in_reg_w_en;
    logic [4:0]  in_rdest;
    logic [63:0] in_wb_data;
    logic [4:0]  rs1_idx;
    logic [63:0] rs1_data;
    logic [4:0]  rs2_idx;
    logic [63:0] rs2_data;
    logic [63:0] retire_cnt;
    logic        halt;
    logic [63:0] halt_code;
    logic        cmt_valid;
    logic [63:0] cmt_pc;
    logic [31:0] cmt_ins;
    logic        cmt_wen;
    logic [4:0]  cmt_rdest;
    logic [63:0] cmt_wdata;

    int vectors = 0;
    int miscompares = 0;

    ysyx_22041071_wb #(.XLEN(64), .HALT_INS(32'h0010_0073)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ins(in_ins), .in_reg_w_en(in_reg_w_en), .in_rdest(in_rdest),
        .in_wb_data(in_wb_data), .rs1_idx(rs1_idx), .rs1_data(rs1_data),
        .rs2_idx(rs2_idx), .rs2_data(rs2_data), .retire_cnt(retire_cnt), .halt(halt),
        .halt_code(halt_code), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_ins(cmt_ins),
        .cmt_wen(cmt_wen), .cmt_rdest(cmt_rdest), .cmt_wdata(cmt_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                         input logic wen, input logic [4:0] rd, input logic [63:0] wd);
        in_valid = v; in_pc = pc; in_ins = ins; in_reg_w_en = wen; in_rdest = rd; in_wb_data = wd;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        rs1_idx = 5'd5; rs2_idx = 5'd10;
        drive(1'b0, 64'h0, NOP, 1'b0, 5'd0, 64'h0);
        do_reset();
        #1;
        vectors++; if (retire_cnt !== 64'd0) begin miscompares++; $display("FAIL reset_cnt got %h exp 0", retire_cnt); end
        vectors++; if (halt !== 1'b0) begin miscompares++; $display("FAIL reset_halt got %b exp 0", halt); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        vectors++; if (cmt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_cmt_valid got %b exp 0", cmt_valid); end
        vectors++; if (rs1_data !== 64'd0) begin miscompares++; $display("FAIL reset_rs1 got %h exp 0", rs1_data); end
    endtask

    task automatic test_write_read();
        rs1_idx = 5'd5;
        drive(1'b1, 64'h8000_0100, NOP, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001);
        vectors++; if (rs1_data !== 64'hDEAD_BEEF_0000_0001) begin miscompares++; $display("FAIL bypass_rs1 got %h exp DEADBEEF00000001", rs1_data); end
        tick();
        drive(1'b0, 64'h0, NOP, 1'b1, 5'd5, 64'h1234);
        vectors++; if (rs1_data !== 64'hDEAD_BEEF_0000_0001) begin miscompares++; $display("FAIL rf_rs1 got %h exp DEADBEEF00000001", rs1_data); end
        vectors++; if (retire_cnt !== 64'd1) begin miscompares++; $display("FAIL wr_cnt got %0d exp 1", retire_cnt); end
        vectors++; if (cmt_valid !== DT) begin miscompares++; $display("FAIL wr_cmt_valid got %b exp %b", cmt_valid, DT); end
        vectors++; if (cmt_rdest !== (DT ? 5'd5 : 5'd0)) begin miscompares++; $display("FAIL wr_cmt_rdest got %0d", cmt_rdest); end
        vectors++; if (cmt_wdata !== (DT ? 64'hDEAD_BEEF_0000_0001 : 64'd0)) begin miscompares++; $display("FAIL wr_cmt_wdata got %h", cmt_wdata); end
        vectors++; if (cmt_pc !== (DT ? 64'h8000_0100 : 64'd0)) begin miscompares++; $display("FAIL wr_cmt_pc got %h", cmt_pc); end
        tick();
        vectors++; if (cmt_valid !== 1'b0) begin miscompares++; $display("FAIL wr_cmt_drop got %b exp 0", cmt_valid); end
        vectors++; if (cmt_rdest !== (DT ? 5'd5 : 5'd0)) begin miscompares++; $display("FAIL wr_cmt_hold got %0d", cmt_rdest); end
        // No bypass without a handshake
        rs1_idx = 5'd7;
        drive(1'b0, 64'h0, NOP, 1'b1, 5'd7, 64'h77);
        vectors++; if (rs1_data !== 64'd0) begin miscompares++; $display("FAIL nobypass_rs1 got %h exp 0", rs1_data); end
    endtask

    task automatic test_x0();
        rs2_idx = 5'd0;
        drive(1'b1, 64'h8000_0104, NOP, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        vectors++; if (rs2_data !== 64'd0) begin miscompares++; $display("FAIL x0_bypass got %h exp 0", rs2_data); end
        tick();
        drive(1'b0, 64'h0, NOP, 1'b0, 5'd0, 64'h0);
        vectors++; if (rs2_data !== 64'd0) begin miscompares++; $display("FAIL x0_rf got %h exp 0", rs2_data); end
        vectors++; if (retire_cnt !== 64'd2) begin miscompares++; $display("FAIL x0_cnt got %0d exp 2", retire_cnt); end
        vectors++; if (cmt_wen !== DT) begin miscompares++; $display("FAIL x0_cmt_wen got %b exp %b", cmt_wen, DT); end
        vectors++; if (cmt_rdest !== 5'd0) begin miscompares++; $display("FAIL x0_cmt_rdest got %0d exp 0", cmt_rdest); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 64'h1000 + 64'(4 * i), NOP, 1'b1, 5'(i + 1), 64'h100 + 64'(i));
            tick();
            vectors++; if (cmt_valid !== DT) begin miscompares++; $display("FAIL b2b_cmt_valid[%0d] got %b exp %b", i, cmt_valid, DT); end
            vectors++; if (cmt_pc !== (DT ? 64'h1000 + 64'(4 * i) : 64'd0)) begin miscompares++; $display("FAIL b2b_cmt_pc[%0d] got %h", i, cmt_pc); end
            vectors++; if (retire_cnt !== 64'(i + 1)) begin miscompares++; $display("FAIL b2b_cnt[%0d] got %0d exp %0d", i, retire_cnt, i + 1); end
        end
        rs1_idx = 5'd4; rs2_idx = 5'd10;
        drive(1'b0, 64'h0, NOP, 1'b0, 5'd0, 64'h0);
        tick();
        vectors++; if (cmt_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_cmt_end got %b exp 0", cmt_valid); end
        vectors++; if (cmt_pc !== (DT ? 64'h1024 : 64'd0)) begin miscompares++; $display("FAIL b2b_cmt_pc_hold got %h", cmt_pc); end
        vectors++; if (retire_cnt !== 64'd10) begin miscompares++; $display("FAIL b2b_cnt_final got %0d exp 10", retire_cnt); end
        vectors++; if (rs1_data !== 64'h103) begin miscompares++; $display("FAIL b2b_x4 got %h exp 103", rs1_data); end
        vectors++; if (rs2_data !== 64'h109) begin miscompares++; $display("FAIL b2b_x10 got %h exp 109", rs2_data); end
    endtask

    task automatic test_halt();
        drive(1'b1, 64'h2000, NOP, 1'b1, 5'd10, 64'h0);
        tick();
        drive(1'b1, 64'h2004, HALT, 1'b0, 5'd0, 64'h0);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL halt_pre_ready got %b exp 1", in_ready); end
        tick();
        rs1_idx = 5'd4;
        drive(1'b1, 64'h2008, NOP, 1'b1, 5'd4, 64'hAA);
        vectors++; if (halt !== 1'b1) begin miscompares++; $display("FAIL halt_flag got %b exp 1", halt); end
        vectors++; if (halt_code !== 64'd0) begin miscompares++; $display("FAIL halt_code got %h exp 0", halt_code); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL halt_ready got %b exp 0", in_ready); end
        vectors++; if (retire_cnt !== 64'd12) begin miscompares++; $display("FAIL halt_cnt got %0d exp 12", retire_cnt); end
        vectors++; if (cmt_ins !== (DT ? HALT : 32'd0)) begin miscompares++; $display("FAIL halt_cmt_ins got %h", cmt_ins); end
        vectors++; if (rs1_data !== 64'h103) begin miscompares++; $display("FAIL halt_nobypass got %h exp 103", rs1_data); end
        tick();
        vectors++; if (retire_cnt !== 64'd12) begin miscompares++; $display("FAIL halt_cnt_frozen got %0d exp 12", retire_cnt); end
        vectors++; if (cmt_valid !== 1'b0) begin miscompares++; $display("FAIL halt_cmt_drop got %b exp 0", cmt_valid); end
        vectors++; if (halt !== 1'b1) begin miscompares++; $display("FAIL halt_sticky got %b exp 1", halt); end
        vectors++; if (rs1_data !== 64'h103) begin miscompares++; $display("FAIL halt_nowrite got %h exp 103", rs1_data); end
        // Nonzero exit code taken from x10
        do_reset();
        drive(1'b1, 64'h3000, NOP, 1'b1, 5'd10, 64'h55AA);
        tick();
        drive(1'b1, 64'h3004, HALT, 1'b0, 5'd0, 64'h0);
        tick();
        drive(1'b0, 64'h0, NOP, 1'b0, 5'd0, 64'h0);
        vectors++; if (halt_code !== 64'h55AA) begin miscompares++; $display("FAIL halt_code_x10 got %h exp 55AA", halt_code); end
        vectors++; if (retire_cnt !== 64'd2) begin miscompares++; $display("FAIL halt2_cnt got %0d exp 2", retire_cnt); end
    endtask

    task automatic test_reset_override();
        do_reset();
        rs1_idx = 5'd3;
        drive(1'b1, 64'h4000, NOP, 1'b1, 5'd3, 64'd7);
        tick();
        drive(1'b0, 64'h0, NOP, 1'b0, 5'd0, 64'h0);
        vectors++; if (rs1_data !== 64'd7) begin miscompares++; $display("FAIL ovr_pre_x3 got %h exp 7", rs1_data); end
        reset = 1'b1;
        drive(1'b1, 64'h4004, NOP, 1'b1, 5'd3, 64'd9);
        tick();
        reset = 1'b0;
        drive(1'b0, 64'h0, NOP, 1'b0, 5'd0, 64'h0);
        vectors++; if (rs1_data !== 64'd0) begin miscompares++; $display("FAIL ovr_x3 got %h exp 0", rs1_data); end
        vectors++; if (retire_cnt !== 64'd0) begin miscompares++; $display("FAIL ovr_cnt got %0d exp 0", retire_cnt); end
        vectors++; if (halt !== 1'b0) begin miscompares++; $display("FAIL ovr_halt got %b exp 0", halt); end
        vectors++; if (cmt_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_cmt_valid got %b exp 0", cmt_valid); end
        vectors++; if (cmt_pc !== 64'd0) begin miscompares++; $display("FAIL ovr_cmt_pc got %h exp 0", cmt_pc); end
    endtask

    initial begin
        reset = 1'b1;
        rs1_idx = 5'd0; rs2_idx = 5'd0;
        drive(1'b0, 64'h0, NOP, 1'b0, 5'd0, 64'h0);
        test_reset();
        test_write_read();
        test_x0();
        test_back_to_back();
        test_halt();
        test_reset_override();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
